// File: rtl/mult_div_pkg.sv
// Shared types for the multicycle multiply/divide unit.
// Optional unsigned ops are enabled with MULT_DIV_UNSIGNED_EN.
package mult_div_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W     = $clog2(WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_e;

    typedef enum logic {
        OP_MULT,
        OP_DIV
    } op_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between control unit and mult/div unit.
// Adds unsigned_op when MULT_DIV_UNSIGNED_EN is defined.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);

    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             mult_start;
    logic             div_start;
`ifdef MULT_DIV_UNSIGNED_EN
    logic             unsigned_op;
`endif
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
`ifdef MULT_DIV_UNSIGNED_EN
        output unsigned_op,
`endif
        output a_in,
        output b_in,
        output mult_start,
        output div_start,
        input  hi_out,
        input  lo_out,
        input  busy,
        input  done,
        input  div_zero
    );

    modport slave (
`ifdef MULT_DIV_UNSIGNED_EN
        input  unsigned_op,
`endif
        input  a_in,
        input  b_in,
        input  mult_start,
        input  div_start,
        output hi_out,
        output lo_out,
        output busy,
        output done,
        output div_zero
    );

endinterface

// File: rtl/mult_div_sign_fix.sv
// Conditional two's-complement negation of a {hi, lo} result pair.
// Multiply negates all 2*WIDTH bits; divide negates hi and lo separately.
module mult_div_sign_fix
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] val_i,
    input  logic               sign_a_i,
    input  logic               sign_b_i,
    input  op_e                op_i,
    output logic [2*WIDTH-1:0] val_o
);

    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0]    neg_full;
    logic [WIDTH-1:0] neg_hi;
    logic [WIDTH-1:0] neg_lo;

    assign neg_full = -val_i;
    assign neg_hi   = -val_i[W2-1:WIDTH];
    assign neg_lo   = -val_i[WIDTH-1:0];

    always_comb begin
        val_o = val_i;
        unique case (op_i)
            OP_MULT: begin
                if (sign_a_i ^ sign_b_i) begin
                    val_o = neg_full;
                end
            end
            OP_DIV: begin
                if (sign_a_i) begin
                    val_o[W2-1:WIDTH] = neg_hi;
                end
                if (sign_a_i ^ sign_b_i) begin
                    val_o[WIDTH-1:0] = neg_lo;
                end
            end
            default: val_o = val_i;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV producing the HI/LO pair (shift-add / restoring).
// Define MULT_DIV_UNSIGNED_EN to add unsigned_op (MULTU/DIVU).
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);

    localparam int CW = $clog2(WIDTH);
    localparam int W2 = 2 * WIDTH;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             dz_q, dz_d;

    logic             uns;
    logic             in_sa;
    logic             in_sb;
    logic             start;
    op_e              in_op;
    logic [W2-1:0]    mag;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [W2-1:0]    fixed;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

`ifdef MULT_DIV_UNSIGNED_EN
    assign uns = bus.unsigned_op;
`else
    assign uns = 1'b0;
`endif

    assign in_sa = ~uns & bus.a_in[WIDTH-1];
    assign in_sb = ~uns & bus.b_in[WIDTH-1];
    assign start = bus.mult_start | bus.div_start;
    assign in_op = bus.mult_start ? OP_MULT : OP_DIV;

    // Divide-mode fix negates hi by sign_a and lo by sign_a^sign_b,
    // so feeding sign_a^sign_b as the second sign yields |a|, |b|.
    mult_div_sign_fix #(.WIDTH(WIDTH)) u_mag (
        .val_i    ({bus.a_in, bus.b_in}),
        .sign_a_i (in_sa),
        .sign_b_i (in_sa ^ in_sb),
        .op_i     (OP_DIV),
        .val_o    (mag)
    );

    assign mag_a = mag[W2-1:WIDTH];
    assign mag_b = mag[WIDTH-1:0];

    mult_div_sign_fix #(.WIDTH(WIDTH)) u_fix (
        .val_i    (acc_q),
        .sign_a_i (sa_q),
        .sign_b_i (sb_q),
        .op_i     (op_q),
        .val_o    (fixed)
    );

    // acc holds {partial product, multiplier} or {remainder, quotient}.
    assign mul_sum   = {1'b0, acc_q[W2-1:WIDTH]}
                     + (acc_q[0] ? {1'b0, opd_q} : '0);
    assign div_shift = acc_q[W2-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opd_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= '0;
            acc_q   <= '0;
            opd_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opd_q   <= opd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opd_d   = opd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = in_op;
                    sa_d  = in_sa;
                    sb_d  = in_sb;
                    cnt_d = '0;
                    dz_d  = 1'b0;
                    if (in_op == OP_DIV && bus.b_in == '0) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else if (in_op == OP_MULT) begin
                        opd_d   = mag_a;
                        acc_d   = {{WIDTH{1'b0}}, mag_b};
                        state_d = RUN;
                    end else begin
                        opd_d   = mag_b;
                        acc_d   = {{WIDTH{1'b0}}, mag_a};
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (op_q == OP_MULT) begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end else if (!div_diff[WIDTH]) begin
                    acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                hi_d    = fixed[W2-1:WIDTH];
                lo_d    = fixed[WIDTH-1:0];
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.hi_out   = hi_q;
        bus.lo_out   = lo_q;
        bus.busy     = (state_q == RUN) || (state_q == FIX);
        bus.done     = (state_q == DONE);
        bus.div_zero = (state_q == DONE) && dz_q;
    end

    a_done_not_busy: assert property (
        @(posedge clk) disable iff (reset) bus.done |-> !bus.busy);

    a_dz_with_done: assert property (
        @(posedge clk) disable iff (reset) bus.div_zero |-> bus.done);

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: fixed vector table, corner sequences,
// and random ops checked against a 64-bit arithmetic model.
module tb_mult_div_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dz;
    } vec_t;

    vec_t vecs[$];

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact 64-bit product; C-style truncating / and %.
    task automatic ref_op(input bit is_div, input logic [31:0] a,
                          input logic [31:0] b, output bit dz);
        longint sa, sb, p, q, r;
        sa = $signed(a);
        sb = $signed(b);
        dz = 1'b0;
        if (!is_div) begin
            p    = sa * sb;
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (b == 32'd0) begin
            dz = 1'b1;
        end else begin
            q    = sa / sb;
            r    = sa % sb;
            m_hi = r[31:0];
            m_lo = q[31:0];
        end
    endtask

    task automatic run_op(input bit is_div, input logic [31:0] a,
                          input logic [31:0] b, output int lat,
                          output int busy_n, output bit dz);
        @(negedge clk);
        bus.a_in       = a;
        bus.b_in       = b;
        bus.mult_start = !is_div;
        bus.div_start  = is_div;
        @(negedge clk);
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
        lat    = 1;
        busy_n = 0;
        while (!bus.done && lat < 100) begin
            busy_n += int'(bus.busy);
            @(negedge clk);
            lat++;
        end
        dz = bus.div_zero;
    endtask

    task automatic check_op(input string tag, input bit is_div,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo,
                            input bit edz);
        int lat, busy_n;
        bit dz;
        run_op(is_div, a, b, lat, busy_n, dz);
        chk({tag, ".latency"}, lat, edz ? 1 : 34);
        chk({tag, ".busy_cycles"}, busy_n, edz ? 0 : 33);
        chk({tag, ".div_zero"}, dz, edz);
        chk({tag, ".hi"}, bus.hi_out, ehi);
        chk({tag, ".lo"}, bus.lo_out, elo);
        @(negedge clk);
        chk({tag, ".done_width"}, bus.done, 1'b0);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, ".hi"}, bus.hi_out, 32'd0);
        chk({tag, ".lo"}, bus.lo_out, 32'd0);
        chk({tag, ".busy"}, bus.busy, 1'b0);
        chk({tag, ".done"}, bus.done, 1'b0);
        chk({tag, ".div_zero"}, bus.div_zero, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        int s;
        unique case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: begin
                s = int'($urandom_range(0, 40)) - 20;
                return s;
            end
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int   pulses;
        int   dones;
        bit   is_div, edz;
        logic [31:0] ra, rb;

        bus.a_in       = '0;
        bus.b_in       = '0;
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
`ifdef MULT_DIV_UNSIGNED_EN
        bus.unsigned_op = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        reset = 1'b0;

        vecs.push_back('{1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
        vecs.push_back('{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h1, 1'b0});
        vecs.push_back('{1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0});
        vecs.push_back('{1'b0, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, 1'b0});
        vecs.push_back('{1'b1, 32'd5, 32'd0, 32'h1, 32'h2345_6780, 1'b1});
        vecs.push_back('{1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0});
        vecs.push_back('{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h3, 1'b0});
        vecs.push_back('{1'b1, 32'd3, 32'd5, 32'd3, 32'd0, 1'b0});
        vecs.push_back('{1'b0, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0});

        foreach (vecs[i]) begin
            check_op($sformatf("vec%0d", i), vecs[i].is_div, vecs[i].a,
                     vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);
        end

        // Both starts together, then a stray mult_start mid-run.
        @(negedge clk);
        bus.a_in       = 32'd6;
        bus.b_in       = 32'hFFFF_FFFC;
        bus.mult_start = 1'b1;
        bus.div_start  = 1'b1;
        @(negedge clk);
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 80; c++) begin
            if (c == 9) begin
                bus.a_in       = 32'd1000;
                bus.b_in       = 32'd1000;
                bus.mult_start = 1'b1;
            end
            if (c == 10) bus.mult_start = 1'b0;
            if (bus.done) begin
                pulses++;
                if (pulses == 1) begin
                    chk("both.latency", c, 34);
                    chk("both.hi", bus.hi_out, 32'hFFFF_FFFF);
                    chk("both.lo", bus.lo_out, 32'hFFFF_FFE8);
                    chk("both.div_zero", bus.div_zero, 1'b0);
                end
            end
            @(negedge clk);
        end
        chk("both.done_pulses", pulses, 1);

        // Reset in the middle of RUN.
        @(negedge clk);
        bus.a_in       = 32'd7;
        bus.b_in       = 32'hFFFF_FFFD;
        bus.mult_start = 1'b1;
        @(negedge clk);
        bus.mult_start = 1'b0;
        repeat (14) @(negedge clk);
        chk("midreset.busy_before", bus.busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_zero("midreset");
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            dones += int'(bus.done);
        end
        chk("midreset.no_done", dones, 0);
        check_op("postreset", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        m_hi = 32'd2;
        m_lo = 32'd14;
        for (int i = 0; i < 150; i++) begin
            is_div = 1'($urandom_range(0, 1));
            ra     = pick();
            rb     = ($urandom_range(0, 9) == 0) ? 32'd0 : pick();
            ref_op(is_div, ra, rb, edz);
            check_op($sformatf("rnd%0d", i), is_div, ra, rb, m_hi, m_lo, edz);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multicycle signed multiply/divide unit for the MIPS-subset CPU. It produces the HI/LO register pair that the HI/LO select mux forwards to the register-write data mux. The control unit pulses a start strobe with operands from RegA/RegB, stalls while busy is high, and writes back on done. It also raises a divide-by-zero flag for the exception logic.

Parameters:
WIDTH, 32, operand width; HI and LO are WIDTH bits each; iteration count equals WIDTH.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state and outputs
a_in  in  WIDTH  multiplicand / dividend (RegA)
b_in  in  WIDTH  multiplier / divisor (RegB)
mult_start  in  1  one-cycle request for signed multiply (MULT)
div_start  in  1  one-cycle request for signed divide (DIV)
hi_out  out  WIDTH  product upper half / remainder
lo_out  out  WIDTH  product lower half / quotient
busy  out  1  high while an operation is in flight
done  out  1  one-cycle pulse when hi_out/lo_out have just been updated or an op has ended
div_zero  out  1  one-cycle pulse, coincident with done, when a divide had b_in == 0

Behaviour:
- Reset (synchronous, active-high, clk/reset fixed): state IDLE, hi_out=0, lo_out=0, busy=0, done=0, div_zero=0, counter=0.
- States: IDLE, RUN, FIX, DONE.
  - IDLE: a start is accepted only here.
    - Operands are latched as magnitudes; the result signs are recorded.
    - Transition to RUN with counter=0.
  - RUN: one iteration per cycle for WIDTH cycles.
    - Multiply uses shift-add on a 2*WIDTH accumulator.
    - Divide uses restoring division: shift the remainder left, trial-subtract the divisor, set the quotient bit.
    - After counter==WIDTH-1, transition to FIX.
  - FIX: apply sign correction.
    - Product sign = sign(a) XOR sign(b).
    - Quotient sign = sign(a) XOR sign(b); remainder takes the sign of the dividend.
    - Register the results into hi_out/lo_out at the end of this cycle. Transition to DONE.
  - DONE: done=1 for exactly this cycle. Transition to IDLE.
- Latency: start sampled at edge k -> done high during cycle k+WIDTH+2 (34 cycles at WIDTH=32). busy is high during RUN and FIX only.
- Simultaneous mult_start and div_start: multiply wins; the divide request is dropped.
- Start while not IDLE: ignored, with no effect on the operation in flight.
- Divide by zero (b_in==0 at acceptance):
  - Go directly IDLE -> DONE.
  - done=1 and div_zero=1 for one cycle; hi_out/lo_out unchanged.
- Overflow -2^(WIDTH-1) / -1: lo_out=0x80000000, hi_out=0. No flag is raised; this matches the magnitude-then-negate datapath.
- Multiply is exact; the 64-bit signed product is split HI:LO.
- Division truncates toward zero. Example: -7/2 -> lo=-3, hi=-1.
- hi_out/lo_out hold their value until the next completed operation; they never show intermediate values.
- Reset mid-operation: aborts immediately, with all outputs per the reset values; no done pulse.

Optional Feature:
MULT_DIV_UNSIGNED_EN
- Defined: adds input port unsigned_op (1 bit), sampled together with the start strobe.
  - When unsigned_op=1, operands are taken as unsigned (MULTU/DIVU) and FIX performs no negation.
  - Divide-by-zero handling is the same as for signed operations.
- Undefined: the port is absent and all operations are signed.

Decomposition:
- Package mult_div_pkg:
  - state enum (IDLE/RUN/FIX/DONE).
  - op enum (OP_MULT, OP_DIV).
  - localparam CNT_W = $clog2(WIDTH).
- One sub-module, mult_div_sign_fix: combinational two's-complement conditional negation of the 2*WIDTH result given the two sign bits and the op. It is used in FIX and for taking magnitudes at acceptance.

Test Plan:
- MULT a=7, b=-3 -> after 34 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
- MULT a=0x7FFFFFFF, b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- DIV b=0 with prior hi/lo=0x12345678/0x9ABCDEF0 -> done and div_zero high one cycle after start, hi/lo unchanged, busy never high.
- Both starts in the same cycle, then mult_start again at cycle 10 -> only a multiply executes, the second start is ignored, one done pulse.
- reset asserted at RUN cycle 15 -> next cycle all outputs 0, state IDLE; a new DIV 100/7 then yields lo=14, hi=2.
